// File: rtl/irq_gen_pkg.sv
// -----------------------------------------------------------------------------
// irq_gen_pkg
// Shared types and constants for the external-interrupt stimulus generator
// (irq_trigger_gen and its per-channel FSM irq_gen_channel).
//   ch_state_e       : per-channel FSM state
//   MODE_LEVEL/PULSE : channel assertion mode
//   ACK_ADDR_DEFAULT : default acknowledge word address
//   word_match()     : compare two byte addresses at word granularity
// -----------------------------------------------------------------------------
package irq_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ASSERT = 3'd3,
        ST_LEAVE  = 3'd4
    } ch_state_e;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;

    // Byte-offset bits are irrelevant for both trigger PCs and the ack store.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return (a & ~32'h3) == (b & ~32'h3);
    endfunction

endpackage

// File: rtl/irq_gen_channel.sv
// -----------------------------------------------------------------------------
// irq_gen_channel
// One interrupt channel: waits for its trigger PC, counts out the programmed
// delay, asserts its request (level until ack, or a fixed-length pulse), then
// re-arms only after the PC has moved off the trigger address.
// Optional macro IRQ_GEN_LOG_EN: print a line on each assertion and ack-clear.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   cfg_sel_i     : configuration write addressed to this channel
//   cfg_pc_i      : trigger PC (bits [1:0] ignored)
//   cfg_count_i   : fires before retiring, 0 = disabled
//   cfg_delay_i   : cycles from match to assertion
//   cfg_mode_i    : MODE_LEVEL / MODE_PULSE
//   pc_i          : CPU architectural PC
//   ack_i         : acknowledge store seen this cycle
//   irq_o         : registered request
//   fire_o        : this edge enters ASSERT (feeds the shared fire counter)
// -----------------------------------------------------------------------------
module irq_gen_channel
    import irq_gen_pkg::*;
#(
    parameter int CH_IDX    = 0,
    parameter int PULSE_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_sel_i,
    input  logic [31:0]      cfg_pc_i,
    input  logic [CNT_W-1:0] cfg_count_i,
    input  logic [CNT_W-1:0] cfg_delay_i,
    input  logic             cfg_mode_i,
    input  logic [31:0]      pc_i,
    input  logic             ack_i,
    output logic             irq_o,
    output logic             fire_o
);

    // Pulse counter holds PULSE_LEN-1 down to 0.
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    ch_state_e        state_q;
    logic [31:0]      trig_pc_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] dly_q;
    logic [PW-1:0]    pcnt_q;
    logic             mode_q;
    logic             irq_q;

    logic pc_hit;
    assign pc_hit = word_match(pc_i, trig_pc_q);

    // A config write on the entry edge overrides the transition into ASSERT.
    assign fire_o = (state_q == ST_WAIT) && (dly_q == '0) && !cfg_sel_i;
    assign irq_o  = irq_q;

    // NOTE: all state uses non-blocking assignments so every channel and the
    // top-level counters see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            trig_pc_q <= '0;
            count_q   <= '0;
            delay_q   <= '0;
            dly_q     <= '0;
            pcnt_q    <= '0;
            mode_q    <= MODE_LEVEL;
            irq_q     <= 1'b0;
        end else if (cfg_sel_i) begin
            trig_pc_q <= cfg_pc_i;
            count_q   <= cfg_count_i;
            delay_q   <= cfg_delay_i;
            mode_q    <= cfg_mode_i;
            irq_q     <= 1'b0;
            state_q   <= (cfg_count_i != '0) ? ST_ARMED : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (pc_hit) begin
                        dly_q   <= delay_q;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dly_q == '0) begin
                        state_q <= ST_ASSERT;
                        irq_q   <= 1'b1;
                        count_q <= count_q - CNT_W'(1);
                        pcnt_q  <= PW'(PULSE_LEN - 1);
`ifdef IRQ_GEN_LOG_EN
                        $display("#interrupt@%0d pc=%h t=%0t", CH_IDX, trig_pc_q, $time);
`endif
                    end else begin
                        dly_q <= dly_q - CNT_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (mode_q == MODE_PULSE) begin
                        if (pcnt_q == '0) begin
                            state_q <= ST_LEAVE;
                            irq_q   <= 1'b0;
                        end else begin
                            pcnt_q <= pcnt_q - PW'(1);
                        end
                    end else if (ack_i) begin
                        state_q <= ST_LEAVE;
                        irq_q   <= 1'b0;
`ifdef IRQ_GEN_LOG_EN
                        $display("#ack@%0d", CH_IDX);
`endif
                    end
                end
                ST_LEAVE: begin
                    // Hold off re-arming while the CPU is still on the trigger PC.
                    if (count_q == '0) begin
                        state_q <= ST_IDLE;
                    end else if (!pc_hit) begin
                        state_q <= ST_ARMED;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/irq_trigger_gen.sv
// -----------------------------------------------------------------------------
// irq_trigger_gen
// External-interrupt stimulus generator for the CPU benches. NCH independent
// channels fire when their programmed PC retires; level-mode requests clear on
// a store to ACK_ADDR, pulse-mode requests after PULSE_LEN cycles.
// Optional macro IRQ_GEN_LOG_EN: per-channel assertion/ack log lines.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cfg_we          : configuration write strobe
//   cfg_ch          : channel written (ignored if >= NCH)
//   cfg_pc          : trigger PC
//   cfg_count       : fires before retiring, 0 = disabled
//   cfg_delay       : match-to-assert delay in cycles
//   cfg_mode        : 0 level, 1 pulse
//   macroscopic_pc  : CPU architectural PC
//   m_data_addr     : data bus address
//   m_data_byteen   : data bus byte enables (non-zero = store)
//   irq             : per-channel request
//   interrupt       : OR of irq
//   fired_total     : saturating count of all assertions since reset
// -----------------------------------------------------------------------------
module irq_trigger_gen
    import irq_gen_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter logic [31:0] ACK_ADDR  = ACK_ADDR_DEFAULT,
    parameter int          PULSE_LEN = 3,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [31:0]      cfg_pc,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic             cfg_mode,
    input  logic [31:0]      macroscopic_pc,
    input  logic [31:0]      m_data_addr,
    input  logic [3:0]       m_data_byteen,
    output logic [NCH-1:0]   irq,
    output logic             interrupt,
    output logic [15:0]      fired_total
);

    logic           ack;
    logic [NCH-1:0] cfg_sel;
    logic [NCH-1:0] fire;
    logic [15:0]    fired_total_q;
    logic [15:0]    fired_total_d;
    logic [3:0]     fire_cnt;
    logic [16:0]    fire_sum;

    assign ack = (|m_data_byteen) && ((m_data_addr & ~32'h3) == ACK_ADDR);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        // Channel indices >= NCH never match any generated slot.
        assign cfg_sel[c] = cfg_we && (cfg_ch == 3'(c));

        irq_gen_channel #(
            .CH_IDX   (c),
            .PULSE_LEN(PULSE_LEN),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cfg_sel_i  (cfg_sel[c]),
            .cfg_pc_i   (cfg_pc),
            .cfg_count_i(cfg_count),
            .cfg_delay_i(cfg_delay),
            .cfg_mode_i (cfg_mode),
            .pc_i       (macroscopic_pc),
            .ack_i      (ack),
            .irq_o      (irq[c]),
            .fire_o     (fire[c])
        );
    end

    // Several channels may enter ASSERT on one edge: add their popcount.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        fire_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            fire_cnt = fire_cnt + 4'(fire[c]);
        end
        fire_sum      = {1'b0, fired_total_q} + 17'(fire_cnt);
        fired_total_d = fire_sum[16] ? 16'hFFFF : fire_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fired_total_q <= '0;
        end else begin
            fired_total_q <= fired_total_d;
        end
    end

    assign fired_total = fired_total_q;
    assign interrupt   = |irq;

endmodule

// File: tb/tb_irq_trigger_gen.sv
// -----------------------------------------------------------------------------
// tb_irq_trigger_gen
// Self-checking bench for irq_trigger_gen. A timestamp-based reference model
// (per channel: armed flag, scheduled fire cycle, pulse end cycle, re-arm
// guard) predicts irq/interrupt/fired_total, compared on every falling edge.
// Directed scenarios add hand-computed literal expectations, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_trigger_gen;

    localparam int          NCH       = 4;
    localparam logic [31:0] ACK       = 32'h0000_7F20;
    localparam int          PULSE_LEN = 3;
    localparam int          CNT_W     = 8;
    localparam logic [31:0] IDLE_PC   = 32'h0000_1000;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [31:0]      cfg_pc;
    logic [CNT_W-1:0] cfg_count;
    logic [CNT_W-1:0] cfg_delay;
    logic             cfg_mode;
    logic [31:0]      macroscopic_pc;
    logic [31:0]      m_data_addr;
    logic [3:0]       m_data_byteen;
    logic [NCH-1:0]   irq;
    logic             interrupt;
    logic [15:0]      fired_total;

    irq_trigger_gen #(
        .NCH      (NCH),
        .ACK_ADDR (ACK),
        .PULSE_LEN(PULSE_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_pc        (cfg_pc),
        .cfg_count     (cfg_count),
        .cfg_delay     (cfg_delay),
        .cfg_mode      (cfg_mode),
        .macroscopic_pc(macroscopic_pc),
        .m_data_addr   (m_data_addr),
        .m_data_byteen (m_data_byteen),
        .irq           (irq),
        .interrupt     (interrupt),
        .fired_total   (fired_total)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event timestamps) ----------------
    int          cyc_n = 0;
    logic [31:0] m_pc      [NCH];
    int          m_count   [NCH];
    int          m_delay   [NCH];
    bit          m_mode    [NCH];
    bit          m_armed   [NCH];
    bit          m_hi      [NCH];
    bit          m_guard   [NCH];
    int          m_fire_at [NCH];
    int          m_hi_end  [NCH];
    int          m_total = 0;
    int          m_entries;
    bit          m_ack;
    bit          m_hit;

    always @(posedge clk) begin
        m_ack = (m_data_byteen != 4'b0) && ((m_data_addr >> 2) == (ACK >> 2));
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_pc[c] = '0; m_count[c] = 0; m_delay[c] = 0; m_mode[c] = 1'b0;
                m_armed[c] = 1'b0; m_hi[c] = 1'b0; m_guard[c] = 1'b0;
                m_fire_at[c] = -1; m_hi_end[c] = 0;
            end
            m_total = 0;
        end else begin
            m_entries = 0;
            for (int c = 0; c < NCH; c++) begin
                m_hit = (macroscopic_pc >> 2) == (m_pc[c] >> 2);
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_pc[c] = cfg_pc; m_count[c] = int'(cfg_count);
                    m_delay[c] = int'(cfg_delay); m_mode[c] = cfg_mode;
                    m_armed[c] = (cfg_count != 0); m_hi[c] = 1'b0;
                    m_guard[c] = 1'b0; m_fire_at[c] = -1;
                end else if (m_hi[c]) begin
                    if ((!m_mode[c] && m_ack) || (m_mode[c] && cyc_n == m_hi_end[c])) begin
                        m_hi[c]    = 1'b0;
                        m_guard[c] = (m_count[c] != 0);
                    end
                end else if (m_fire_at[c] >= 0) begin
                    if (cyc_n == m_fire_at[c]) begin
                        m_fire_at[c] = -1;
                        m_hi[c]      = 1'b1;
                        m_count[c]   = m_count[c] - 1;
                        m_hi_end[c]  = cyc_n + PULSE_LEN;
                        m_entries++;
                    end
                end else if (m_guard[c]) begin
                    if (!m_hit) begin
                        m_guard[c] = 1'b0;
                        m_armed[c] = 1'b1;
                    end
                end else if (m_armed[c] && m_hit) begin
                    m_armed[c]   = 1'b0;
                    m_fire_at[c] = cyc_n + 1 + m_delay[c];
                end
            end
            m_total = (m_total + m_entries > 65535) ? 65535 : m_total + m_entries;
        end
        cyc_n++;
    end

    // ---------------- per-cycle compare ----------------
    logic [NCH-1:0] exp_irq;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) exp_irq[c] = m_hi[c];
            check("model_irq", 32'(irq), 32'(exp_irq));
            check("model_interrupt", 32'(interrupt), 32'(|exp_irq));
            check("model_fired_total", 32'(fired_total), 32'(m_total));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic program_ch(input int ch, input logic [31:0] pc, input int cnt,
                              input int dly, input bit mode);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_pc = pc;
        cfg_count = CNT_W'(cnt); cfg_delay = CNT_W'(dly); cfg_mode = mode;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic ack_store();
        m_data_addr = 32'h0000_7F22; m_data_byteen = 4'b0100;
        step();
        m_data_addr = '0; m_data_byteen = 4'b0;
    endtask

    bit [6:0] pulse_pat;

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_pc = '0;
        cfg_count = '0; cfg_delay = '0; cfg_mode = 1'b0;
        macroscopic_pc = IDLE_PC; m_data_addr = '0; m_data_byteen = '0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_interrupt", 32'(interrupt), 32'h0);
        check("reset_fired_total", 32'(fired_total), 32'h0);

        // Level basic
        program_ch(0, 32'h0000_301C, 1, 0, 0);
        macroscopic_pc = 32'h0000_301C; step();
        macroscopic_pc = IDLE_PC;
        check("level_wait_slot", 32'(irq), 32'h0);
        step();
        check("level_irq_high", 32'(irq), 32'h1);
        check("level_interrupt", 32'(interrupt), 32'h1);
        ack_store();
        check("level_ack_clear", 32'(irq), 32'h0);
        check("level_fired", 32'(fired_total), 32'd1);
        macroscopic_pc = 32'h0000_301C; step(3);
        macroscopic_pc = IDLE_PC; step(3);
        check("level_no_refire", 32'(irq), 32'h0);

        // Stall guard: PC held on the trigger across the ack
        program_ch(1, 32'h0000_3040, 2, 0, 0);
        macroscopic_pc = 32'h0000_3040; step(2);
        check("stall_first_fire", 32'(irq), 32'h2);
        ack_store();
        check("stall_ack_clear", 32'(irq), 32'h0);
        step(7);
        check("stall_held_no_refire", 32'(irq), 32'h0);
        check("stall_fired", 32'(fired_total), 32'd2);
        macroscopic_pc = IDLE_PC; step();
        macroscopic_pc = 32'h0000_3040; step();
        macroscopic_pc = IDLE_PC; step();
        check("stall_second_fire", 32'(irq), 32'h2);
        check("stall_fired2", 32'(fired_total), 32'd3);
        ack_store();
        macroscopic_pc = 32'h0000_3040; step(2);
        macroscopic_pc = IDLE_PC; step(2);
        check("stall_retired", 32'(irq), 32'h0);

        // Pulse mode, delay 2: rises 3 edges after the match, high 3 cycles
        program_ch(2, 32'h0000_3080, 1, 2, 1);
        macroscopic_pc = 32'h0000_3080; step();
        macroscopic_pc = IDLE_PC;
        pulse_pat = 7'b0111000;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("pulse_slot%0d", i), 32'(irq[2]), 32'(pulse_pat[i]));
            if (i == 3) begin
                m_data_addr = 32'h0000_7F20; m_data_byteen = 4'b1111;
            end else begin
                m_data_addr = '0; m_data_byteen = 4'b0;
            end
            step();
        end
        check("pulse_fired", 32'(fired_total), 32'd4);

        // Multi-channel: same trigger PC, one ack clears both
        program_ch(0, 32'h0000_3000, 1, 0, 0);
        program_ch(3, 32'h0000_3000, 1, 0, 0);
        macroscopic_pc = 32'h0000_3000; step();
        macroscopic_pc = IDLE_PC; step();
        check("multi_both_high", 32'(irq), 32'h9);
        check("multi_fired", 32'(fired_total), 32'd6);
        ack_store();
        check("multi_single_ack", 32'(irq), 32'h0);

        // Config override while asserted
        program_ch(0, 32'h0000_3100, 3, 0, 0);
        macroscopic_pc = 32'h0000_3100; step();
        macroscopic_pc = IDLE_PC; step();
        check("override_pre", 32'(irq), 32'h1);
        program_ch(0, 32'h0000_3100, 0, 0, 0);
        check("override_drop", 32'(irq), 32'h0);
        macroscopic_pc = 32'h0000_3100; step(3);
        macroscopic_pc = IDLE_PC; step();
        check("override_ignored", 32'(irq), 32'h0);
        check("override_fired", 32'(fired_total), 32'd7);

        // Reset mid-WAIT
        program_ch(1, 32'h0000_3200, 1, 5, 0);
        macroscopic_pc = 32'h0000_3200; step();
        macroscopic_pc = IDLE_PC; step(2);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_fired_zero", 32'(fired_total), 32'h0);
        step(10);
        check("rst_no_assert", 32'(irq), 32'h0);
        macroscopic_pc = 32'h0000_3200; step(3);
        macroscopic_pc = IDLE_PC; step();
        check("rst_cfg_lost", 32'(irq), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            macroscopic_pc = 32'h0000_3000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_pc    = 32'h0000_3000 + 32'(4 * $urandom_range(0, 3));
            cfg_count = CNT_W'($urandom_range(0, 3));
            cfg_delay = CNT_W'($urandom_range(0, 3));
            cfg_mode  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                m_data_byteen = 4'($urandom_range(1, 15));
                m_data_addr   = ($urandom_range(0, 1) == 0) ? (ACK + 32'($urandom_range(0, 3)))
                                                            : 32'h0000_7F30;
            end else begin
                m_data_byteen = 4'b0;
                m_data_addr   = ACK;
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; cfg_we = 1'b0; m_data_byteen = 4'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
